apb_program_loader: RTL and testbench

Host-side APB master that sits directly upstream of the RISC-V core top and drives its APB slave port.
- Streams a program image from a host valid/ready interface into core instruction memory, with instruction_load_start asserted throughout the load.
- Releases the core via core_select and waits for run_complete, bounded by a watchdog.
- Reads back a result window over APB and returns it to the host as a stream.

---
 rtl/apb_program_loader.sv | 174 +++++++++++++++++
 tb/tb_apb_program_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_program_loader.sv
// rtl/apb_program_loader.sv - APB master that loads a program into the core, runs it and reads results back
module apb_program_loader #(
  parameter int DATA_LENGTH    = 32,
  parameter int ADDRESS_LENGTH = 32,
  parameter int LEN_W          = 12,
  parameter int RUN_TIMEOUT    = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDRESS_LENGTH-1:0] prog_base,
  input  logic [LEN_W-1:0]          prog_len,
  input  logic [ADDRESS_LENGTH-1:0] rd_base,
  input  logic [LEN_W-1:0]          rd_len,
  input  logic [DATA_LENGTH-1:0]    host_wdata,
  input  logic                      host_wvalid,
  output logic                      host_wready,
  output logic [DATA_LENGTH-1:0]    rd_data,
  output logic                      rd_valid,
  output logic [ADDRESS_LENGTH-1:0] addr_in,
  output logic [DATA_LENGTH-1:0]    data_in,
  output logic                      pselect,
  output logic                      pwrite,
  output logic                      pready,
  output logic                      instruction_load_start,
  output logic                      core_select,
  input  logic                      run_complete,
  input  logic [DATA_LENGTH-1:0]    data_out,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout_err
);
  localparam int WD_W = (RUN_TIMEOUT < 2) ? 1 : $clog2(RUN_TIMEOUT + 1);
  localparam logic [WD_W-1:0]           WD_LAST   = WD_W'(RUN_TIMEOUT - 1);
  localparam logic [WD_W-1:0]           WD_ONE    = WD_W'(1);
  localparam logic [ADDRESS_LENGTH-1:0] WORD_STEP = ADDRESS_LENGTH'(4);
  localparam logic [LEN_W-1:0]          CNT_ONE   = LEN_W'(1);

  typedef enum logic [3:0] {
    IDLE, LD_WAIT, LD_SETUP, LD_ACCESS, RUN, RB_SETUP, RB_ACCESS, RB_CAPTURE, FINISH
  } state_t;

  state_t state, state_next;

  logic [LEN_W-1:0]          prog_len_q, rd_len_q, cnt;
  logic [ADDRESS_LENGTH-1:0] rd_base_q, addr_q;
  logic [WD_W-1:0]           wd;
  logic                      wd_expired;

  assign wd_expired = (wd == WD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next             = state;
    host_wready            = 1'b0;
    pselect                = 1'b0;
    pwrite                 = 1'b0;
    pready                 = 1'b0;
    instruction_load_start = 1'b0;
    core_select            = 1'b0;
    rd_valid               = 1'b0;
    busy                   = 1'b1;
    done                   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = (prog_len != '0) ? LD_WAIT : RUN;
      end
      LD_WAIT: begin
        host_wready            = 1'b1;
        instruction_load_start = 1'b1;
        if (host_wvalid) state_next = LD_SETUP;
      end
      LD_SETUP: begin
        pselect                = 1'b1;
        pwrite                 = 1'b1;
        instruction_load_start = 1'b1;
        state_next             = LD_ACCESS;
      end
      LD_ACCESS: begin
        pselect                = 1'b1;
        pwrite                 = 1'b1;
        pready                 = 1'b1;
        instruction_load_start = 1'b1;
        state_next             = (cnt + CNT_ONE < prog_len_q) ? LD_WAIT : RUN;
      end
      RUN: begin
        core_select = 1'b1;
        // run_complete takes priority over a watchdog expiry in the same cycle
        if (run_complete)    state_next = (rd_len_q != '0) ? RB_SETUP : FINISH;
        else if (wd_expired) state_next = FINISH;
      end
      RB_SETUP: begin
        core_select = 1'b1;
        pselect     = 1'b1;
        state_next  = RB_ACCESS;
      end
      RB_ACCESS: begin
        core_select = 1'b1;
        pselect     = 1'b1;
        pready      = 1'b1;
        state_next  = RB_CAPTURE;
      end
      RB_CAPTURE: begin
        core_select = 1'b1;
        rd_valid    = 1'b1;
        state_next  = (cnt + CNT_ONE < rd_len_q) ? RB_SETUP : FINISH;
      end
      FINISH: begin
        done       = !timeout_err;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // addr_q always holds the address of the next transfer; addr_in is only updated on entry to a setup phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prog_len_q  <= '0;
      rd_len_q    <= '0;
      rd_base_q   <= '0;
      addr_q      <= '0;
      cnt         <= '0;
      wd          <= '0;
      addr_in     <= '0;
      data_in     <= '0;
      rd_data     <= '0;
      timeout_err <= 1'b0;
    end else begin
      wd <= (state == RUN) ? wd + WD_ONE : '0;
      case (state)
        IDLE: if (start) begin
          prog_len_q  <= prog_len;
          rd_len_q    <= rd_len;
          rd_base_q   <= rd_base;
          addr_q      <= prog_base;
          cnt         <= '0;
          timeout_err <= 1'b0;
        end
        LD_WAIT: if (host_wvalid) begin
          data_in <= host_wdata;
          addr_in <= addr_q;
          addr_q  <= addr_q + WORD_STEP;
        end
        LD_ACCESS: cnt <= cnt + CNT_ONE;
        RUN: begin
          if (run_complete) begin
            cnt <= '0;
            if (rd_len_q != '0) begin
              addr_in <= rd_base_q;
              addr_q  <= rd_base_q + WORD_STEP;
            end
          end else if (wd_expired) begin
            timeout_err <= 1'b1;
          end
        end
        RB_ACCESS: rd_data <= data_out;
        RB_CAPTURE: begin
          cnt <= cnt + CNT_ONE;
          if (state_next == RB_SETUP) begin
            addr_in <= addr_q;
            addr_q  <= addr_q + WORD_STEP;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_program_loader.sv
// tb/tb_apb_program_loader.sv - scoreboard bench for apb_program_loader with a behavioural core model
`timescale 1ns/1ps
module tb_apb_program_loader;
  localparam int TO = 20;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [31:0] prog_base = '0, rd_base = '0, host_wdata = '0;
  logic [11:0] prog_len = '0, rd_len = '0;
  logic        host_wvalid = 1'b0, run_complete = 1'b0;
  logic        host_wready, rd_valid, pselect, pwrite, pready;
  logic        instruction_load_start, core_select, busy, done, timeout_err;
  logic [31:0] rd_data, addr_in, data_in, data_out;

  apb_program_loader #(.RUN_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .prog_base(prog_base), .prog_len(prog_len), .rd_base(rd_base), .rd_len(rd_len),
    .host_wdata(host_wdata), .host_wvalid(host_wvalid), .host_wready(host_wready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .addr_in(addr_in), .data_in(data_in), .pselect(pselect), .pwrite(pwrite), .pready(pready),
    .instruction_load_start(instruction_load_start), .core_select(core_select),
    .run_complete(run_complete), .data_out(data_out),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Core result memory: every readable address returns a fixed scramble of itself
  function automatic logic [31:0] core_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction
  assign data_out = core_word(addr_in);

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } apb_t;

  apb_t        exp_apb[$];
  logic [31:0] exp_rd[$];
  logic [31:0] words[16];
  int          vectors = 0, miscompares = 0, done_cnt = 0;
  logic        prev_setup = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    apb_t e;
    if (rst) begin
      if (done) done_cnt++;
      if (pselect && host_wready) chk("wready_during_apb", 1'b1, 1'b0);
      if (pselect && pready) begin
        chk("setup_before_access", {prev_setup, prev_addr}, {1'b1, addr_in});
        if (exp_apb.size() == 0) chk("apb_expected", 1'b0, 1'b1);
        else begin
          e = exp_apb.pop_front();
          chk("apb_pwrite", pwrite, e.wr);
          chk("apb_addr", addr_in, e.addr);
          if (e.wr) chk("apb_wdata", data_in, e.data);
          chk("ils_during_transfer", instruction_load_start, e.wr);
        end
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) chk("rd_expected", 1'b0, 1'b1);
        else chk("rd_data", rd_data, exp_rd.pop_front());
      end
    end
    prev_setup = rst && pselect && !pready;
    prev_addr  = addr_in;
  end

  task automatic feed_words(input int first, input int n, input int gap);
    int t;
    for (int i = first; i < first + n; i++) begin
      repeat (gap) @(negedge clk);
      host_wvalid = 1'b1;
      host_wdata  = words[i];
      t = 0;
      while (!host_wready && t < 200) begin @(negedge clk); t++; end
      chk("wready_seen", host_wready, 1'b1);
      @(negedge clk);
      host_wvalid = 1'b0;
    end
  endtask

  task automatic start_seq(input logic [31:0] pbase, input int plen, input logic [31:0] rbase, input int rlen);
    @(negedge clk);
    prog_base = pbase; prog_len = 12'(plen); rd_base = rbase; rd_len = 12'(rlen);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("timeout_err_cleared", timeout_err, 1'b0);
  endtask

  // run_delay < 0 means the core never completes and the watchdog must fire
  task automatic run_seq(input logic [31:0] pbase, input int plen, input logic [31:0] rbase,
                         input int rlen, input int run_delay, input int gap);
    int   d0, c;
    logic expect_done;
    expect_done = (run_delay >= 0);
    for (int i = 0; i < plen; i++) exp_apb.push_back({1'b1, pbase + 32'(4 * i), words[i]});
    if (expect_done)
      for (int i = 0; i < rlen; i++) begin
        exp_apb.push_back({1'b0, rbase + 32'(4 * i), core_word(rbase + 32'(4 * i))});
        exp_rd.push_back(core_word(rbase + 32'(4 * i)));
      end
    d0 = done_cnt;
    start_seq(pbase, plen, rbase, rlen);
    feed_words(0, plen, gap);
    c = 0;
    while (!core_select && c < 200) begin @(negedge clk); c++; end
    chk("run_entered", core_select, 1'b1);
    if (expect_done) begin
      repeat (run_delay) @(negedge clk);
      run_complete = 1'b1;
      @(negedge clk);
      run_complete = 1'b0;
      if (rlen == 0) chk("done_after_run_complete", done, 1'b1);
    end else begin
      c = 0;
      while (!timeout_err && c < 100) begin @(negedge clk); c++; end
      chk("timeout_latency", c, TO);
      chk("core_select_dropped", core_select, 1'b0);
      chk("no_done_on_timeout", done, 1'b0);
    end
    c = 0;
    while (busy && c < 200) begin @(negedge clk); c++; end
    chk("busy_cleared", busy, 1'b0);
    @(negedge clk);
    chk("done_pulses", done_cnt - d0, expect_done);
    chk("apb_all_seen", exp_apb.size(), 0);
    chk("rd_all_seen", exp_rd.size(), 0);
    chk("timeout_err_final", timeout_err, !expect_done);
  endtask

  initial begin
    int c;
    logic [31:0] b;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {pselect, pready, pwrite, instruction_load_start, core_select, busy,
                          done, timeout_err, host_wready, rd_valid}, 10'b0);
    chk("reset_buses", {addr_in, data_in}, 64'b0);
    rst = 1'b1;
    @(negedge clk);

    // load, run, readback
    words[0] = 32'h0050_0093; words[1] = 32'h00A0_0113; words[2] = 32'h0020_81B3;
    run_seq(32'h0, 3, 32'h100, 2, 10, 0);
    // host stalls between words
    for (int i = 0; i < 16; i++) words[i] = $urandom;
    run_seq(32'h40, 4, 32'h200, 1, 3, 5);
    // watchdog, then a start that clears it
    run_seq(32'h80, 1, 32'h300, 2, -1, 0);
    // zero lengths
    run_seq(32'h0, 0, 32'h0, 0, 4, 0);
    // run_complete on the same cycle the watchdog would expire
    run_seq(32'h10, 1, 32'h400, 1, TO - 1, 1);
    // address wrap on load and readback
    run_seq(32'hFFFF_FFFC, 2, 32'hFFFF_FFF8, 3, 2, 0);

    // async reset during the access phase of word 2 of 4
    b = 32'h0000_1000;
    exp_apb.push_back({1'b1, b, words[0]});
    exp_apb.push_back({1'b1, b + 32'd4, words[1]});
    start_seq(b, 4, 32'h500, 1);
    feed_words(0, 2, 0);
    c = 0;
    while (!(pselect && pready) && c < 20) begin @(negedge clk); c++; end
    chk("abort_point_addr", addr_in, b + 32'd4);
    #1 rst = 1'b0;
    #1;
    chk("async_reset_outputs", {pselect, pready, pwrite, instruction_load_start, core_select, busy,
                                done, timeout_err, host_wready, rd_valid}, 10'b0);
    chk("async_reset_buses", {addr_in, data_in}, 64'b0);
    exp_apb.delete();
    exp_rd.delete();
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", busy, 1'b0);
    run_seq(b, 4, 32'h500, 1, 5, 0);

    // randomized sequences
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 16; i++) words[i] = $urandom;
      run_seq($urandom & 32'hFFFF_FFFC, $urandom_range(0, 6), $urandom & 32'hFFFF_FFFC,
              $urandom_range(0, 4), $urandom_range(0, TO - 1), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
